// File: rtl/fetch_controller_pkg.sv
// Shared types for the fetch controller: state encoding, opcodes, strobe bundle.
// FETCH_CTRL_IRQ_EN adds the interrupt states, the EI opcode decode and IRQ strobes.
package fetch_controller_pkg;

   localparam int WAIT_LIMIT_DEFAULT = 15;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ALU   = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_STORE = 4'h3;
   localparam logic [3:0] OP_JMP   = 4'h4;
   localparam logic [3:0] OP_CALL  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'h6;
   localparam logic [3:0] OP_EI    = 4'h7;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_CALL_PUSH,
      ST_JUMP,
`ifdef FETCH_CTRL_IRQ_EN
      ST_IRQ_PUSH,
      ST_IRQ_VEC,
`endif
      ST_HALT
   } state_e;

   typedef struct packed {
      logic pc_increment;
      logic pc_load;
      logic pc_push;
      logic pc_push_d;
      logic i_read;
      logic mem_read;
      logic mem_write;
      logic alu_en;
      logic jmp_src_en;
      logic stack_we;
`ifdef FETCH_CTRL_IRQ_EN
      logic irq_ack;
      logic vec_en;
`endif
   } ctrl_t;

   // Strobes that belong to a state; registered alongside the state itself.
   function automatic ctrl_t decode_ctrl(input state_e st, input logic [3:0] opcode);
      ctrl_t c;
      c = '0;
      case (st)
         ST_FETCH: begin
            c.pc_push = 1'b1;
            c.i_read  = 1'b1;
         end
         ST_DECODE: c.pc_increment = 1'b1;
         ST_EXEC:   c.alu_en = (opcode == OP_ALU);
         ST_MEM: begin
            c.mem_read  = (opcode == OP_LOAD);
            c.mem_write = (opcode == OP_STORE);
         end
         ST_CALL_PUSH: begin
            c.pc_push_d = 1'b1;
            c.stack_we  = 1'b1;
         end
         ST_JUMP: begin
            c.pc_load    = 1'b1;
            c.jmp_src_en = 1'b1;
         end
`ifdef FETCH_CTRL_IRQ_EN
         ST_IRQ_PUSH: begin
            c.pc_push_d = 1'b1;
            c.stack_we  = 1'b1;
            c.irq_ack   = 1'b1;
         end
         ST_IRQ_VEC: begin
            c.pc_load = 1'b1;
            c.vec_en  = 1'b1;
         end
`endif
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fetch_controller_wait_timer.sv
// Ready-less cycle counter for fetch and memory waits.
// limit_reached is high in the cycle whose ready-less outcome would reach LIMIT.
module wait_timer
   import fetch_controller_pkg::*;
#(
   parameter int LIMIT = WAIT_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic limit_reached
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      limit_reached = (int'(count_q) >= LIMIT - 1);
      count_d       = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !limit_reached) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch/decode sequencer with registered datapath strobes.
// Define FETCH_CTRL_IRQ_EN for the irq/irq_ack/vec_en interrupt path and the EI opcode.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FETCH_CTRL_IRQ_EN
   input  logic        irq,
   output logic        irq_ack,
   output logic        vec_en,
`endif
   input  logic [15:0] i_data,
   input  logic        i_ready,
   input  logic        mem_ready,
   output logic        pc_increment,
   output logic        pc_load,
   output logic        pc_push,
   output logic        pc_push_d,
   output logic        i_read,
   output logic [15:0] ir,
   output logic        mem_read,
   output logic        mem_write,
   output logic        alu_en,
   output logic        jmp_src_en,
   output logic        stack_we,
   output logic        halted,
   output logic        bus_err,
   output logic        illegal
);

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic        halted_q, halted_d;
   logic        bus_err_q, bus_err_d;
   logic        illegal_q, illegal_d;
   logic        timer_clear, timer_en, limit_reached;
   logic [3:0]  opcode;
`ifdef FETCH_CTRL_IRQ_EN
   logic        ie_q, ie_d;
`endif

   assign opcode = ir_q[15:12];

   wait_timer #(
      .LIMIT(WAIT_LIMIT)
   ) u_wait_timer (
      .clk          (clk),
      .rst          (rst),
      .clear        (timer_clear),
      .enable       (timer_en),
      .limit_reached(limit_reached)
   );

   // FETCH only accepts i_ready once its strobe is actually on the bus,
   // which holds off the first post-reset cycle where strobes are still 0.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      bus_err_d = bus_err_q;
      illegal_d = illegal_q;
      timer_en  = 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
      ie_d      = ie_q;
`endif
      case (state_q)
         ST_FETCH: begin
            if (ctrl_q.i_read) begin
               if (i_ready) begin
                  ir_d    = i_data;
                  state_d = ST_DECODE;
               end else if (limit_reached) begin
                  state_d   = ST_HALT;
                  bus_err_d = 1'b1;
               end else begin
                  timer_en = 1'b1;
               end
            end
         end
         ST_DECODE: begin
            case (opcode)
               OP_NOP, OP_ALU:    state_d = ST_EXEC;
               OP_LOAD, OP_STORE: state_d = ST_MEM;
               OP_JMP:            state_d = ST_JUMP;
               OP_CALL:           state_d = ST_CALL_PUSH;
               OP_HALT:           state_d = ST_HALT;
`ifdef FETCH_CTRL_IRQ_EN
               OP_EI:             state_d = ST_EXEC;
`endif
               default: begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_EXEC: begin
`ifdef FETCH_CTRL_IRQ_EN
            if (opcode == OP_EI) begin
               ie_d = 1'b1;
            end
`endif
            state_d = ST_FETCH;
         end
         ST_MEM: begin
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (limit_reached) begin
               state_d   = ST_HALT;
               bus_err_d = 1'b1;
            end else begin
               timer_en = 1'b1;
            end
         end
         ST_CALL_PUSH: state_d = ST_JUMP;
         ST_JUMP:      state_d = ST_FETCH;
`ifdef FETCH_CTRL_IRQ_EN
         ST_IRQ_PUSH: begin
            ie_d    = 1'b0;
            state_d = ST_IRQ_VEC;
         end
         ST_IRQ_VEC:   state_d = ST_FETCH;
`endif
         ST_HALT:      state_d = ST_HALT;
         default:      state_d = ST_FETCH;
      endcase
`ifdef FETCH_CTRL_IRQ_EN
      // Interrupts are taken only on a fresh entry into FETCH.
      if (state_d == ST_FETCH && state_q != ST_FETCH && irq && ie_q) begin
         state_d = ST_IRQ_PUSH;
      end
`endif
      timer_clear = (state_d != state_q);
      halted_d    = (state_d == ST_HALT);
      ctrl_d      = decode_ctrl(state_d, opcode);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         ir_q      <= '0;
         ctrl_q    <= '0;
         halted_q  <= 1'b0;
         bus_err_q <= 1'b0;
         illegal_q <= 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
         ie_q      <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         ctrl_q    <= ctrl_d;
         halted_q  <= halted_d;
         bus_err_q <= bus_err_d;
         illegal_q <= illegal_d;
`ifdef FETCH_CTRL_IRQ_EN
         ie_q      <= ie_d;
`endif
      end
   end

   assign pc_increment = ctrl_q.pc_increment;
   assign pc_load      = ctrl_q.pc_load;
   assign pc_push      = ctrl_q.pc_push;
   assign pc_push_d    = ctrl_q.pc_push_d;
   assign i_read       = ctrl_q.i_read;
   assign mem_read     = ctrl_q.mem_read;
   assign mem_write    = ctrl_q.mem_write;
   assign alu_en       = ctrl_q.alu_en;
   assign jmp_src_en   = ctrl_q.jmp_src_en;
   assign stack_we     = ctrl_q.stack_we;
   assign ir           = ir_q;
   assign halted       = halted_q;
   assign bus_err      = bus_err_q;
   assign illegal      = illegal_q;
`ifdef FETCH_CTRL_IRQ_EN
   assign irq_ack      = ctrl_q.irq_ack;
   assign vec_en       = ctrl_q.vec_en;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; the IRQ sequence runs when FETCH_CTRL_IRQ_EN is defined.
module tb_fetch_controller;

   localparam logic [9:0] S_INC    = 10'h200;
   localparam logic [9:0] S_LOAD   = 10'h100;
   localparam logic [9:0] S_PUSH   = 10'h080;
   localparam logic [9:0] S_PUSHD  = 10'h040;
   localparam logic [9:0] S_IREAD  = 10'h020;
   localparam logic [9:0] S_MREAD  = 10'h010;
   localparam logic [9:0] S_MWRITE = 10'h008;
   localparam logic [9:0] S_ALU    = 10'h004;
   localparam logic [9:0] S_JSRC   = 10'h002;
   localparam logic [9:0] S_SWE    = 10'h001;
   localparam logic [9:0] S_FETCH  = S_PUSH | S_IREAD;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] i_data;
   logic        i_ready, mem_ready;
   logic        pc_increment, pc_load, pc_push, pc_push_d, i_read;
   logic [15:0] ir;
   logic        mem_read, mem_write, alu_en, jmp_src_en, stack_we;
   logic        halted, bus_err, illegal;
   logic [9:0]  strobes;
   logic [2:0]  flags;
   int          test_count = 0;
   int          fail_count = 0;
`ifdef FETCH_CTRL_IRQ_EN
   logic        irq, irq_ack, vec_en;
`endif

   fetch_controller #(.WAIT_LIMIT(15)) dut (
      .clk         (clk),
      .rst         (rst),
`ifdef FETCH_CTRL_IRQ_EN
      .irq         (irq),
      .irq_ack     (irq_ack),
      .vec_en      (vec_en),
`endif
      .i_data      (i_data),
      .i_ready     (i_ready),
      .mem_ready   (mem_ready),
      .pc_increment(pc_increment),
      .pc_load     (pc_load),
      .pc_push     (pc_push),
      .pc_push_d   (pc_push_d),
      .i_read      (i_read),
      .ir          (ir),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .alu_en      (alu_en),
      .jmp_src_en  (jmp_src_en),
      .stack_we    (stack_we),
      .halted      (halted),
      .bus_err     (bus_err),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   assign strobes = {pc_increment, pc_load, pc_push, pc_push_d, i_read,
                     mem_read, mem_write, alu_en, jmp_src_en, stack_we};
   assign flags   = {halted, bus_err, illegal};

   task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
      test_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, step past the edge, then check the exclusivity rules.
   task automatic applyStimulus(input logic rdy, input logic [15:0] data, input logic mrdy);
      i_ready   = rdy;
      i_data    = data;
      mem_ready = mrdy;
      @(posedge clk);
      #1;
      checkOutput("inv_inc_load", {15'b0, pc_increment & pc_load}, 16'h0);
      checkOutput("inv_pushd_jsrc", {15'b0, pc_push_d & jmp_src_en}, 16'h0);
      checkOutput("inv_rd_wr", {15'b0, mem_read & mem_write}, 16'h0);
   endtask

   task automatic doReset(input string tag);
      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput({tag, "_strobes"}, {6'b0, strobes}, 16'h0);
      checkOutput({tag, "_flags"}, {13'b0, flags}, 16'h0);
      checkOutput({tag, "_ir"}, ir, 16'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput({tag, "_fetch"}, {6'b0, strobes}, {6'b0, S_FETCH});
   endtask

   // Runs a fetch-to-decode handshake and checks the decode cycle.
   task automatic fetchInstr(input string tag, input logic [15:0] word);
      applyStimulus(1'b1, word, 1'b0);
      checkOutput({tag, "_dec"}, {6'b0, strobes}, {6'b0, S_INC});
      checkOutput({tag, "_ir"}, ir, word);
   endtask

   task automatic expectCycle(input string tag, input logic [9:0] exp_strobes, input logic [2:0] exp_flags);
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput({tag, "_strobes"}, {6'b0, strobes}, {6'b0, exp_strobes});
      checkOutput({tag, "_flags"}, {13'b0, flags}, {13'b0, exp_flags});
   endtask

   initial begin
      rst       = 1'b1;
      i_ready   = 1'b0;
      i_data    = 16'h0;
      mem_ready = 1'b0;
`ifdef FETCH_CTRL_IRQ_EN
      irq       = 1'b0;
`endif
      applyStimulus(1'b0, 16'h0, 1'b0);
      doReset("rst0");

      fetchInstr("nop", 16'h0000);
      expectCycle("nop_exec", 10'h0, 3'b000);
      expectCycle("nop_c4", S_FETCH, 3'b000);

      fetchInstr("alu", 16'h1234);
      expectCycle("alu_exec", S_ALU, 3'b000);
      expectCycle("alu_fetch", S_FETCH, 3'b000);

      fetchInstr("call", 16'h5000);
      expectCycle("call_push", S_PUSHD | S_SWE, 3'b000);
      expectCycle("call_jump", S_LOAD | S_JSRC, 3'b000);
      expectCycle("call_fetch", S_FETCH, 3'b000);

      fetchInstr("jmp", 16'h4ABC);
      expectCycle("jmp_jump", S_LOAD | S_JSRC, 3'b000);
      expectCycle("jmp_fetch", S_FETCH, 3'b000);

      // LOAD: three ready-less MEM cycles, ready in the fourth.
      fetchInstr("load", 16'h2000);
      expectCycle("load_m1", S_MREAD, 3'b000);
      expectCycle("load_m2", S_MREAD, 3'b000);
      expectCycle("load_m3", S_MREAD, 3'b000);
      expectCycle("load_m4", S_MREAD, 3'b000);
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("load_done", {6'b0, strobes}, {6'b0, S_FETCH});
      checkOutput("load_flags", {13'b0, flags}, 16'h0);

      fetchInstr("store", 16'h3001);
      expectCycle("store_m1", S_MWRITE, 3'b000);
      applyStimulus(1'b0, 16'h0, 1'b1);
      checkOutput("store_done", {6'b0, strobes}, {6'b0, S_FETCH});

      // Fetch answered on the 15th cycle: ready on the limit cycle wins.
      for (int i = 1; i <= 14; i++) begin
         expectCycle("fwait", S_FETCH, 3'b000);
      end
      fetchInstr("fwait_ok", 16'h0000);
      checkOutput("fwait_ok_flags", {13'b0, flags}, 16'h0);
      expectCycle("fwait_exec", 10'h0, 3'b000);
      expectCycle("fwait_fetch", S_FETCH, 3'b000);

      // Fetch never answered: 15 ready-less cycles then bus error.
      for (int i = 1; i <= 14; i++) begin
         expectCycle("fto_wait", S_FETCH, 3'b000);
      end
      expectCycle("fto_halt", 10'h0, 3'b110);
      applyStimulus(1'b1, 16'h0000, 1'b1);
      checkOutput("fto_stuck", {13'b0, flags}, 16'h6);
      checkOutput("fto_stuck_strb", {6'b0, strobes}, 16'h0);
      doReset("rst_fto");

      // Memory never answers.
      fetchInstr("mto", 16'h2100);
      for (int i = 1; i <= 15; i++) begin
         expectCycle("mto_wait", S_MREAD, 3'b000);
      end
      expectCycle("mto_halt", 10'h0, 3'b110);
      doReset("rst_mto");

      fetchInstr("illf", 16'hF000);
      expectCycle("illf_halt", 10'h0, 3'b101);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'h0000, 1'b1);
         checkOutput("illf_stuck", {6'b0, strobes}, 16'h0);
      end
      checkOutput("illf_flags", {13'b0, flags}, 16'h5);
      doReset("rst_illf");

      fetchInstr("halt", 16'h6000);
      expectCycle("halt_state", 10'h0, 3'b100);
      expectCycle("halt_hold", 10'h0, 3'b100);
      doReset("rst_halt");

`ifndef FETCH_CTRL_IRQ_EN
      fetchInstr("op7", 16'h7000);
      expectCycle("op7_illegal", 10'h0, 3'b101);
      doReset("rst_op7");
`endif

      // Reset while CALL is pushing: no jump may follow.
      fetchInstr("rcall", 16'h5000);
      expectCycle("rcall_push", S_PUSHD | S_SWE, 3'b000);
      rst = 1'b1;
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("rcall_rst1", {6'b0, strobes}, 16'h0);
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("rcall_rst2", {6'b0, strobes}, 16'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 1'b0);
      checkOutput("rcall_fetch", {6'b0, strobes}, {6'b0, S_FETCH});

`ifdef FETCH_CTRL_IRQ_EN
      fetchInstr("irq_alu", 16'h1000);
      expectCycle("irq_exec", S_ALU, 3'b000);
      irq = 1'b1;
      expectCycle("irq_push", S_PUSHD | S_SWE, 3'b000);
      checkOutput("irq_push_ack", {14'b0, irq_ack, vec_en}, 16'h2);
      expectCycle("irq_vec", S_LOAD, 3'b000);
      checkOutput("irq_vec_en", {14'b0, irq_ack, vec_en}, 16'h1);
      expectCycle("irq_fetch", S_FETCH, 3'b000);
      fetchInstr("irq_masked", 16'h0000);
      expectCycle("irq_masked_exec", 10'h0, 3'b000);
      expectCycle("irq_masked_fetch", S_FETCH, 3'b000);
      checkOutput("irq_masked_ack", {14'b0, irq_ack, vec_en}, 16'h0);
      fetchInstr("ei", 16'h7000);
      expectCycle("ei_exec", 10'h0, 3'b000);
      expectCycle("ei_fetch", S_FETCH, 3'b000);
      fetchInstr("irq2_nop", 16'h0000);
      expectCycle("irq2_exec", 10'h0, 3'b000);
      expectCycle("irq2_push", S_PUSHD | S_SWE, 3'b000);
      checkOutput("irq2_ack", {14'b0, irq_ack, vec_en}, 16'h2);
      irq = 1'b0;
      expectCycle("irq2_vec", S_LOAD, 3'b000);
      expectCycle("irq2_fetch", S_FETCH, 3'b000);
`endif

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: ready-less cycles tolerated in a fetch or memory wait before bus error.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 i_data  in  16  instruction word; i_ready  in  1  instruction memory has data this cycle.
REQ-005 mem_ready  in  1  data memory completed the access this cycle.
REQ-006 pc_increment, pc_load, pc_push, pc_push_d  out  1 each  program-counter controls.
REQ-007 i_read  out  1  instruction fetch strobe; ir  out  16  latched instruction.
REQ-008 mem_read, mem_write, alu_en, jmp_src_en, stack_we  out  1 each  datapath strobes (jmp_src_en: register file drives d_bus).
REQ-009 halted, bus_err, illegal  out  1 each  status flags.

Function
REQ-010 States: FETCH, DECODE, EXEC, MEM, CALL_PUSH, JUMP, HALT; opcode = ir[15:12].
REQ-011 FETCH: pc_push=1, i_read=1; on i_ready, ir<=i_data, go DECODE; else stay.
REQ-012 DECODE: pc_increment=1 for exactly one cycle; next: 0/1 (NOP/ALU)->EXEC, 2/3 (LOAD/STORE)->MEM, 4 (JMP)->JUMP, 5 (CALL)->CALL_PUSH, 6 (HALT)->HALT, any other->HALT with illegal<=1.
REQ-013 EXEC: alu_en=1 only when opcode 1; one cycle; ->FETCH.
REQ-014 MEM: mem_read=1 (opcode 2) or mem_write=1 (opcode 3) held until mem_ready; on mem_ready ->FETCH.
REQ-015 CALL_PUSH: pc_push_d=1, stack_we=1 for one cycle (pushes return address, already incremented); ->JUMP.
REQ-016 JUMP: pc_load=1, jmp_src_en=1 for one cycle; ->FETCH.
REQ-017 HALT: halted=1, all strobes 0; exit only by rst.
REQ-018 Wait counter clears on entry to FETCH/MEM, increments each ready-less cycle; reaching WAIT_LIMIT ->HALT with bus_err<=1; ready on the limit cycle wins.
REQ-019 Invariants: pc_increment and pc_load never both 1; pc_push_d and jmp_src_en never both 1; at most one of mem_read/mem_write.
REQ-020 Non-wait instruction latency: NOP 3 cycles, JMP 3, CALL 4 (FETCH with immediate i_ready).
REQ-021 All outputs are decoded from registered state; no input-to-output combinational path except none.

Reset
REQ-022 rst: state FETCH, ir=0, counter=0, halted/bus_err/illegal=0, all strobes 0 in the cycle after rst samples high.
REQ-023 rst mid-wait or mid-CALL abandons the operation; no stack_we or pc_load issued after rst.

Configuration
REQ-024 FETCH_CTRL_IRQ_EN defined: adds irq (in, 1), irq_ack (out, 1), vec_en (out, 1) and interrupt-enable flag ie (reset 1).
REQ-025 With FETCH_CTRL_IRQ_EN: on any transition to FETCH with irq=1 and ie=1, go IRQ_PUSH (pc_push_d=1, stack_we=1, irq_ack=1, ie<=0), then IRQ_VEC (pc_load=1, vec_en=1), then FETCH; opcode 7 (EI) sets ie via EXEC.
REQ-026 Without FETCH_CTRL_IRQ_EN: ports absent, opcode 7 illegal, IRQ states absent.

Structure
REQ-027 Shared package holds the state enum, opcode constants (NOP..EI) and WAIT_LIMIT default.
REQ-028 One sub-module, wait_timer: counter with clear/enable inputs and a limit-reached output.

Verification
REQ-029 rst, then NOP with i_ready=1: pc_push/i_read cycle 1, pc_increment cycle 2, FETCH cycle 4; no pc_load.
REQ-030 CALL (0x5000): pc_push_d+stack_we one cycle, then pc_load+jmp_src_en one cycle, never overlapping.
REQ-031 LOAD with mem_ready after 3 cycles: mem_read high exactly 4 cycles, bus_err=0.
REQ-032 i_ready held 0: bus_err=1, halted=1 after WAIT_LIMIT=15 cycles; i_ready on cycle 15 instead: no error.
REQ-033 Opcode 0xF: illegal=1, halted=1, strobes stay 0 until rst; rst clears all flags.
REQ-034 IRQ build: irq=1 during ALU: irq_ack one cycle after EXEC, vector load next; second irq ignored until EI executes.
